// File: rtl/ntt_pkg.sv
// Shared constants for the forward and inverse NTT processing elements.
package ntt_pkg;
  localparam int N    = 9;
  localparam int Q    = 257;
  localparam int INV2 = (Q + 1) / 2;
  localparam int SW   = N + 1;   // add/sub width before the conditional correction
  localparam int PW   = 2 * N;   // raw product width
  localparam logic [SW-1:0] Q_EXT = SW'(Q);
endpackage

// File: rtl/intt_pe_pipe_if.sv
// Valid/ready butterfly stream: operands in, x/y results out.
interface intt_pe_pipe_if;
  import ntt_pkg::*;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] u;
  logic [N-1:0] v;
  logic [N-1:0] w;
  logic         halve;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;

  modport master (output in_valid, u, v, w, halve, out_ready,
                  input  in_ready, out_valid, x, y);
  modport slave  (input  in_valid, u, v, w, halve, out_ready,
                  output in_ready, out_valid, x, y);
endinterface

// File: rtl/intt_pe_pipe_modred.sv
// Combinational reduction of a 2*LOGQ-bit product modulo the constant Q.
module modred #(
  parameter int LOGQ = 9,
  parameter int Q    = 257
) (
  input  logic [2*LOGQ-1:0] p,
  output logic [LOGQ-1:0]   r
);
  localparam logic [2*LOGQ-1:0] QW = (2*LOGQ)'(Q);
  logic [2*LOGQ-1:0] rem;

  assign rem = p % QW;
  assign r   = rem[LOGQ-1:0];
endmodule

// File: rtl/intt_pe_pipe.sv
// Gentleman-Sande inverse-NTT butterfly: x=(u+v), y=(u-v)*w, optional *2^-1, all mod Q.
module intt_pe_pipe
  import ntt_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  intt_pe_pipe_if.slave  io
);
  localparam int STAGES = 3;

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  logic [SW-1:0]     sum, diff, sq, rq;
  logic [N-1:0]      s_c, d_c, x_c, y_c, r;
  logic [N-1:0]      s1, d1, w1, s2;
  logic              h1, h2;
  logic [PW-1:0]     p2;

  // Whole pipe moves as one; a stalled output freezes every stage behind it.
  assign adv         = !vld_pipe[STAGES] || io.out_ready;
  assign io.in_ready = adv;
  assign io.out_valid = vld_pipe[STAGES];

  always_comb begin
    sum  = {1'b0, io.u} + {1'b0, io.v};
    diff = {1'b0, io.u} - {1'b0, io.v};
    s_c  = (sum >= Q_EXT) ? N'(sum - Q_EXT) : sum[N-1:0];
    d_c  = diff[N] ? N'(diff + Q_EXT) : diff[N-1:0];
  end

  modred #(.LOGQ(N), .Q(Q)) u_modred (.p(p2), .r(r));

  // Halving mod Q: odd values are made even by adding Q before the shift.
  always_comb begin
    sq  = {1'b0, s2} + Q_EXT;
    rq  = {1'b0, r}  + Q_EXT;
    x_c = s2;
    y_c = r;
    if (h2) begin
      x_c = s2[0] ? sq[N:1] : {1'b0, s2[N-1:1]};
      y_c = r[0]  ? rq[N:1] : {1'b0, r[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      d1       <= '0;
      w1       <= '0;
      h1       <= 1'b0;
      s2       <= '0;
      p2       <= '0;
      h2       <= 1'b0;
      io.x     <= '0;
      io.y     <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], io.in_valid};
      s1       <= s_c;
      d1       <= d_c;
      w1       <= io.w;
      h1       <= io.halve;
      s2       <= s1;
      p2       <= PW'(d1) * PW'(w1);
      h2       <= h1;
      io.x     <= x_c;
      io.y     <= y_c;
    end
  end
endmodule

// File: tb/tb_intt_pe_pipe.sv
// Directed and randomized checks of the INTT butterfly PE against a modular-arithmetic model.
module tb_intt_pe_pipe;
  localparam int Q    = 257;
  localparam int INV2 = 129;

  typedef struct { int x; int y; } exp_t;

  logic clk = 1'b0;
  logic rst;
  intt_pe_pipe_if ifc();

  intt_pe_pipe dut (.clk(clk), .rst(rst), .io(ifc.slave));

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   cur_u, cur_v, cur_w;
  bit   cur_h, cur_iv, cur_or, accepted;
  bit   hold_pend;
  int   hold_x, hold_y;

  always @(posedge clk)
    if (!rst && ifc.in_valid)
      assert (ifc.u < Q && ifc.v < Q && ifc.w < Q)
      else begin
        errors++;
        $error("FAIL in_range u=%0d v=%0d w=%0d", ifc.u, ifc.v, ifc.w);
      end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int u, input int v, input int w, input bit h);
    exp_t e;
    e.x = (u + v) % Q;
    e.y = (((u - v) % Q + Q) % Q * w) % Q;
    if (h) begin
      e.x = (e.x * INV2) % Q;
      e.y = (e.y * INV2) % Q;
    end
    return e;
  endfunction

  task automatic rnd_in();
    cur_u = $urandom_range(0, Q-1);
    cur_v = $urandom_range(0, Q-1);
    cur_w = $urandom_range(0, Q-1);
    cur_h = $urandom_range(0, 1);
  endtask

  // One cycle of the streaming harness; starts and ends just after a falling edge.
  task automatic tick();
    exp_t e;
    ifc.in_valid  = cur_iv;
    ifc.u         = cur_u[8:0];
    ifc.v         = cur_v[8:0];
    ifc.w         = cur_w[8:0];
    ifc.halve     = cur_h;
    ifc.out_ready = cur_or;
    #1;
    if (hold_pend) begin
      chk("hold_valid", ifc.out_valid, 1);
      chk("hold_x", ifc.x, hold_x);
      chk("hold_y", ifc.y, hold_y);
    end
    hold_pend = ifc.out_valid && !ifc.out_ready;
    hold_x    = ifc.x;
    hold_y    = ifc.y;
    if (ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) chk("stale_out", ifc.out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("stream_x", ifc.x, e.x);
        chk("stream_y", ifc.y, e.y);
      end
    end
    accepted = cur_iv && ifc.in_ready;
    if (accepted) exp_q.push_back(model(cur_u, cur_v, cur_w, cur_h));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    cur_iv = 0;
    cur_or = 1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Single butterfly into an empty pipe, with latency and value checks.
  task automatic directed(input int u, input int v, input int w, input bit h,
                          input int ex, input int ey);
    ifc.in_valid  = 1;
    ifc.u         = u[8:0];
    ifc.v         = v[8:0];
    ifc.w         = w[8:0];
    ifc.halve     = h;
    ifc.out_ready = 1;
    #1;
    chk("dir_in_ready", ifc.in_ready, 1);
    @(posedge clk); @(negedge clk);
    ifc.in_valid = 0;
    chk("dir_lat1", ifc.out_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("dir_lat2", ifc.out_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("dir_lat3", ifc.out_valid, 1);
    chk("dir_x", ifc.x, ex);
    chk("dir_y", ifc.y, ey);
    @(posedge clk); @(negedge clk);
    chk("dir_consumed", ifc.out_valid, 0);
  endtask

  initial begin
    int n, cyc;
    bit or_pat [6] = '{1, 0, 0, 1, 0, 1};
    rst = 1;
    ifc.in_valid = 0; ifc.u = 0; ifc.v = 0; ifc.w = 0; ifc.halve = 0; ifc.out_ready = 0;
    cur_iv = 0; cur_or = 0; cur_u = 0; cur_v = 0; cur_w = 0; cur_h = 0; hold_pend = 0;
    @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_x", ifc.x, 0);
    chk("rst_y", ifc.y, 0);
    chk("rst_in_ready", ifc.in_ready, 1);
    @(negedge clk);

    directed(5, 3, 2, 0, 8, 4);
    directed(3, 5, 1, 0, 8, 255);
    directed(256, 256, 256, 0, 255, 0);
    directed(10, 4, 256, 0, 14, 251);
    directed(10, 4, 256, 1, 7, 254);
    directed(77, 12, 0, 0, 89, 0);

    // Back-to-back butterflies under a fixed out_ready pattern.
    n = 0; cyc = 0;
    cur_iv = 1;
    rnd_in();
    while (n < 8 && cyc < 200) begin
      cur_or = or_pat[cyc % 6];
      tick();
      if (accepted) begin n++; rnd_in(); end
      cyc++;
    end
    chk("bp_accepted", n, 8);
    drain();

    // Reset with three butterflies in flight.
    cur_or = 0; cur_iv = 1;
    for (int i = 0; i < 3; i++) begin rnd_in(); tick(); end
    cur_iv = 0;
    ifc.in_valid = 0;
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    chk("rst_mid_valid", ifc.out_valid, 0);
    exp_q.delete();
    hold_pend = 0;
    cur_or = 1;
    for (int i = 0; i < 10; i++) tick();
    directed(1, 2, 3, 0, 3, 254);

    // Long random run with random valid and ready.
    n = 0; cyc = 0;
    rnd_in();
    while (n < 10000 && cyc < 60000) begin
      cur_iv = ($urandom_range(0, 3) != 0);
      cur_or = ($urandom_range(0, 3) != 0);
      tick();
      if (accepted) begin n++; rnd_in(); end
      cyc++;
    end
    chk("rand_accepted", n, 10000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
